// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// Single outstanding request; response is a one-cycle strobe without backpressure.
interface if_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one imem request at a time, holds the
// returned word for decode, and handles flush, misaligned PCs and drain.
module if_stage #(
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IP,
  input  logic        flush,
  if_stage_if.master  imem,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [6:0]  OP,
  output logic        misalign_err,
  output logic [15:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        mis_q, mis_d;
  logic [15:0] cnt_q, cnt_d;
  logic        issue;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!flush) issue = 1'b1;
      end
      S_REQ: begin
        if (flush) begin
          state_d = imem.imem_req_ready ? S_DRAIN : S_IDLE;
        end else if (imem.imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = imem.imem_rsp_valid ? S_IDLE : S_DRAIN;
        end else if (imem.imem_rsp_valid) begin
          instr_d = imem.imem_rsp_data;
          pc_d    = addr_q;
          mis_d   = 1'b0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (instr_ready) begin
          cnt_d = cnt_q + 16'd1;
          issue = 1'b1;
        end
      end
      S_DRAIN: begin
        if (imem.imem_rsp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared by IDLE and an accepted HOLD so fetches issue back-to-back
    if (issue) begin
      if (IP[1:0] == 2'b00) begin
        addr_d  = IP;
        state_d = S_REQ;
      end else begin
        instr_d = NOP_WORD;
        pc_d    = IP;
        mis_d   = 1'b1;
        state_d = S_HOLD;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem.imem_req_valid = (state_q == S_REQ);
  assign imem.imem_addr      = addr_q;
  assign instr_valid         = (state_q == S_HOLD);
  assign instr               = instr_valid ? instr_q : NOP_WORD;
  assign instr_pc            = pc_q;
  assign OP                  = instr[6:0];
  assign misalign_err        = instr_valid & mis_q;
  assign fetch_count         = cnt_q;

endmodule
